// File: rtl/decode_sequencer.sv
// Instruction front end: latches fetched words into IR', decodes them for the ALU
// and sequences MEM / EXEC / WB2 cycles while issuing the commit strobes.
module decode_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_valid,
    input  logic [15:0] ir_data,
    output logic        ir_ready,
    output logic [15:0] instruction,
    output logic [5:0]  encoded_opcode,
    output logic [2:0]  reg_write_addr,
    output logic [2:0]  reg_read_addr,
    output logic [2:0]  rs2_addr,
    output logic        imm_sel,
    output logic [15:0] imm_data,
    output logic        reg_we,
    output logic        reg_we2,
    output logic        sr_we,
    output logic        sp_we,
    output logic        ram_re,
    output logic        ram_we,
    output logic        pc_load,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_EXEC, S_WB2} state_t;
    localparam logic [5:0] OP_RSVD = 6'b111111;

    function automatic logic f_mem_rd(input logic [5:0] op);
        return (op == 6'd26) || (op == 6'd27) || (op == 6'd38);
    endfunction

    function automatic logic f_two_word(input logic [5:0] op);
        return (op == 6'd33) || (op == 6'd34);
    endfunction

    function automatic logic f_reg_we(input logic [5:0] op);
        return (op >= 6'd6  && op <= 6'd14) || (op >= 6'd17 && op <= 6'd22) ||
               (op == 6'd26) || (op == 6'd27) || (op >= 6'd29 && op <= 6'd34);
    endfunction

    function automatic logic f_sp_we(input logic [5:0] op);
        return (op == 6'd25) || (op == 6'd27) || (op == 6'd3) ||
               (op == 6'd36) || (op == 6'd38);
    endfunction

    function automatic logic f_ram_we(input logic [5:0] op);
        return (op == 6'd25) || (op == 6'd28) || (op == 6'd3) || (op == 6'd36);
    endfunction

    function automatic logic f_pc_load(input logic [5:0] op);
        return (op == 6'd0) || (op == 6'd35) || (op == 6'd36) ||
               (op == 6'd3) || (op == 6'd38);
    endfunction

    state_t      r_state, w_state_n;
    logic [15:0] r_instr, r_imm, r_retired;
    logic [5:0]  r_op;
    logic [2:0]  r_rd, r_rs2;
    logic        r_imm_sel;
    logic        r_reg_we, r_reg_we2, r_sr_we, r_sp_we, r_ram_re, r_ram_we, r_pc_load;

    logic [5:0]  w_dec_op, w_op_n;
    logic [2:0]  w_dec_rd, w_dec_rs2;
    logic        w_dec_imm_sel;
    logic [15:0] w_dec_imm;
    logic        w_ready, w_accept, w_retire;
    logic        w_reg_we_n, w_reg_we2_n, w_sr_we_n, w_sp_we_n;
    logic        w_ram_re_n, w_ram_we_n, w_pc_load_n;

    // Word decode; fields are only captured on an accept edge.
    always_comb begin
        w_dec_op      = OP_RSVD;
        w_dec_rd      = 3'd0;
        w_dec_rs2     = 3'd0;
        w_dec_imm_sel = 1'b0;
        w_dec_imm     = 16'd0;
        casez (ir_data[15:12])
            4'b0???: begin
                w_dec_imm_sel = 1'b1;
                w_dec_imm     = {6'b0, ir_data[9:0]};
                w_dec_rd      = ir_data[12:10];
                case (ir_data[14:13])
                    2'b00:   w_dec_op = 6'b001010;
                    2'b01:   w_dec_op = 6'b001011;
                    2'b10:   w_dec_op = 6'b001100;
                    default: w_dec_op = OP_RSVD;
                endcase
            end
            4'b100?: begin
                w_dec_op  = ir_data[12:7];
                w_dec_rd  = ir_data[6:4];
                w_dec_rs2 = ir_data[2:0];
            end
            4'b101?: begin
                w_dec_rd = ir_data[6:4];
                case (ir_data[12:11])
                    2'b00:   w_dec_op = 6'b001101;
                    2'b01:   w_dec_op = 6'b001110;
                    2'b10:   w_dec_op = 6'b001111;
                    default: w_dec_op = OP_RSVD;
                endcase
            end
            4'b1100: w_dec_op = 6'b000000;
            4'b1101: w_dec_op = 6'b100011;
            4'b1110: w_dec_op = 6'b100100;
            default: w_dec_op = OP_RSVD;
        endcase
    end

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_EXEC && !f_two_word(r_op));
    assign w_accept = ir_valid && w_ready;
    assign w_retire = (r_state == S_EXEC && !f_two_word(r_op)) || (r_state == S_WB2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_n = f_mem_rd(w_dec_op) ? S_MEM : S_EXEC;
            S_MEM:  w_state_n = S_EXEC;
            S_EXEC: begin
                if (f_two_word(r_op))  w_state_n = S_WB2;
                else if (w_accept)     w_state_n = f_mem_rd(w_dec_op) ? S_MEM : S_EXEC;
                else                   w_state_n = S_IDLE;
            end
            S_WB2:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // Strobes are computed for the upcoming state so they can be registered.
    always_comb begin
        w_op_n      = w_accept ? w_dec_op : r_op;
        w_reg_we_n  = 1'b0;
        w_reg_we2_n = 1'b0;
        w_sr_we_n   = 1'b0;
        w_sp_we_n   = 1'b0;
        w_ram_re_n  = 1'b0;
        w_ram_we_n  = 1'b0;
        w_pc_load_n = 1'b0;
        case (w_state_n)
            S_MEM:  w_ram_re_n = f_mem_rd(w_op_n);
            S_EXEC: begin
                w_reg_we_n  = f_reg_we(w_op_n);
                w_sr_we_n   = (w_op_n != OP_RSVD);
                w_sp_we_n   = f_sp_we(w_op_n);
                w_ram_we_n  = f_ram_we(w_op_n);
                w_pc_load_n = f_pc_load(w_op_n);
            end
            S_WB2:  w_reg_we2_n = f_two_word(w_op_n);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr   <= 16'd0;
            r_op      <= OP_RSVD;
            r_rd      <= 3'd0;
            r_rs2     <= 3'd0;
            r_imm_sel <= 1'b0;
            r_imm     <= 16'd0;
            r_reg_we  <= 1'b0;
            r_reg_we2 <= 1'b0;
            r_sr_we   <= 1'b0;
            r_sp_we   <= 1'b0;
            r_ram_re  <= 1'b0;
            r_ram_we  <= 1'b0;
            r_pc_load <= 1'b0;
            r_retired <= 16'd0;
        end else begin
            if (w_accept) begin
                r_instr   <= ir_data;
                r_op      <= w_dec_op;
                r_rd      <= w_dec_rd;
                r_rs2     <= w_dec_rs2;
                r_imm_sel <= w_dec_imm_sel;
                r_imm     <= w_dec_imm;
            end
            r_reg_we  <= w_reg_we_n;
            r_reg_we2 <= w_reg_we2_n;
            r_sr_we   <= w_sr_we_n;
            r_sp_we   <= w_sp_we_n;
            r_ram_re  <= w_ram_re_n;
            r_ram_we  <= w_ram_we_n;
            r_pc_load <= w_pc_load_n;
            if (w_retire) r_retired <= r_retired + 16'd1;
        end
    end

    assign ir_ready       = w_ready;
    assign instruction    = r_instr;
    assign encoded_opcode = r_op;
    assign reg_write_addr = r_rd;
    assign reg_read_addr  = r_rd;
    assign rs2_addr       = r_rs2;
    assign imm_sel        = r_imm_sel;
    assign imm_data       = r_imm;
    assign reg_we         = r_reg_we;
    assign reg_we2        = r_reg_we2;
    assign sr_we          = r_sr_we;
    assign sp_we          = r_sp_we;
    assign ram_re         = r_ram_re;
    assign ram_we         = r_ram_we;
    assign pc_load        = r_pc_load;
    assign retired        = r_retired;

endmodule
